// File: rtl/dsp_post_adder.sv
// 48-bit post-adder/accumulator: selects X/Z operands by OPMODE, adds or subtracts with carry-in,
// and drives P, the PCOUT cascade and the carry-out (optionally registered per stage).
module dsp_post_adder #(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int OPMODEREG   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CEOPMODE,
  input  logic        CEP,
  input  logic        CECARRY,
  input  logic [4:0]  OPMODE,
  input  logic        CIN,
  input  logic [35:0] M,
  input  logic [47:0] DAB,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [4:0]  opm_reg;
  logic [4:0]  opm;
  logic [47:0] p_reg;
  logic [47:0] p_next;
  logic        carry_reg;
  logic        carry_next;
  logic [47:0] x_mux;
  logic [47:0] z_mux;
  logic [48:0] sum;

  assign opm = (OPMODEREG != 0) ? opm_reg : OPMODE;

  always_comb begin
    x_mux = '0;
    case (opm[1:0])
      2'd0: x_mux = '0;
      2'd1: x_mux = {{12{M[35]}}, M};
      2'd2: x_mux = p_reg;
      2'd3: x_mux = DAB;
      default: x_mux = '0;
    endcase
  end

  // Feedback always comes from the register; with PREG=0 a P-feedback select is illegal anyway,
  // and sourcing p_reg keeps that case free of a combinational loop.
  always_comb begin
    z_mux = '0;
    case (opm[3:2])
      2'd0: z_mux = '0;
      2'd1: z_mux = PCIN;
      2'd2: z_mux = p_reg;
      2'd3: z_mux = C;
      default: z_mux = '0;
    endcase
  end

  always_comb begin
    if (opm[4]) begin
      sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, CIN});
    end else begin
      sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, CIN};
    end
  end

  assign p_next     = sum[47:0];
  assign carry_next = sum[48];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      opm_reg   <= '0;
      p_reg     <= '0;
      carry_reg <= 1'b0;
    end else begin
      if (CEOPMODE) opm_reg   <= OPMODE;
      if (CEP)      p_reg     <= p_next;
      if (CECARRY)  carry_reg <= carry_next;
    end
  end

  assign P         = (PREG != 0) ? p_reg : p_next;
  assign PCOUT     = P;
  assign CARRYOUT  = (CARRYOUTREG != 0) ? carry_reg : carry_next;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp_post_adder.sv
// Self-checking bench for dsp_post_adder (default parameters): a cycle model pushes expected
// {carry,P} per edge to a queue; scenario tasks pop and compare, plus fixed-value checks.
module tb_dsp_post_adder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CEOPMODE, CEP, CECARRY, CIN;
  logic [4:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] DAB, C, PCIN;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int n_cmp = 0;
  int n_err = 0;

  logic [48:0] exp_q[$];
  logic [48:0] exp;
  logic [4:0]  m_opm = '0;
  logic [47:0] m_p   = '0;
  logic        m_c   = 1'b0;

  dsp_post_adder dut (
    .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CEP(CEP), .CECARRY(CECARRY),
    .OPMODE(OPMODE), .CIN(CIN), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 CLK = ~CLK;

  // Model one rising edge from the current inputs, queue the expected result, sample at negedge.
  task automatic cycle();
    logic [47:0] x, z;
    logic [48:0] s;
    case (m_opm[1:0])
      2'd0: x = '0;
      2'd1: x = {{12{M[35]}}, M};
      2'd2: x = m_p;
      default: x = DAB;
    endcase
    case (m_opm[3:2])
      2'd0: z = '0;
      2'd1: z = PCIN;
      2'd2: z = m_p;
      default: z = C;
    endcase
    if (m_opm[4]) s = {1'b0, z} - ({1'b0, x} + 49'(CIN));
    else          s = {1'b0, z} + {1'b0, x} + 49'(CIN);
    if (!RST) begin
      m_p = '0; m_c = 1'b0; m_opm = '0;
    end else begin
      if (CEP)      m_p   = s[47:0];
      if (CECARRY)  m_c   = s[48];
      if (CEOPMODE) m_opm = OPMODE;
    end
    exp_q.push_back({m_c, m_p});
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_in(input logic [4:0] opm, input logic [35:0] m, input logic [47:0] dab,
                        input logic [47:0] c, input logic cin);
    OPMODE = opm; M = m; DAB = dab; C = c; CIN = cin;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      OPMODE = 5'($urandom); M = 36'({$urandom, $urandom}); DAB = 48'({$urandom, $urandom});
      C = 48'({$urandom, $urandom}); PCIN = 48'({$urandom, $urandom}); CIN = 1'($urandom);
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (P !== 48'd0 || PCOUT !== 48'd0 || CARRYOUT !== 1'b0 || CARRYOUTF !== 1'b0 || exp !== 49'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d P=%h PCOUT=%h CO=%b COF=%b required all zero", i, P, PCOUT, CARRYOUT, CARRYOUTF);
      end
    end
    RST = 1'b1;
    set_in(5'b00000, 36'd0, 48'd0, 48'd0, 1'b1);
    cycle();
    exp = exp_q.pop_front();
    n_cmp++;
    if (P !== 48'd1 || {CARRYOUT, P} !== exp) begin
      n_err++;
      $display("FAIL reset_release P=%h required 000000000001", P);
    end
    $display("reset: released, first edge P=%h", P);
  endtask

  task automatic test_m_select();
    set_in(5'b00001, 36'hFFFFFFFFF, 48'd0, 48'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp || PCOUT !== exp[47:0] || CARRYOUTF !== exp[48]) begin
        n_err++;
        $display("FAIL m_select cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
    end
    n_cmp++;
    if (P !== 48'hFFFF_FFFF_FFFF || CARRYOUT !== 1'b0) begin
      n_err++;
      $display("FAIL m_select_value P=%h CO=%b required ffffffffffff/0", P, CARRYOUT);
    end
    $display("m_select: P=%h CO=%b", P, CARRYOUT);
  endtask

  task automatic test_accumulate();
    set_in(5'b00000, 36'd5, 48'd0, 48'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) OPMODE = 5'b01001;
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp || PCOUT !== exp[47:0]) begin
        n_err++;
        $display("FAIL accumulate cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
    end
    n_cmp++;
    if (P !== 48'd20 || CARRYOUT !== 1'b0) begin
      n_err++;
      $display("FAIL accumulate_value P=%h CO=%b required 000000000014/0", P, CARRYOUT);
    end
    CEP = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if (P !== 48'd20 || {CARRYOUT, P} !== exp) begin
        n_err++;
        $display("FAIL accumulate_hold cyc=%0d P=%h required 000000000014", i, P);
      end
    end
    CEP = 1'b1;
    $display("accumulate: P=%h after hold", P);
  endtask

  task automatic test_wrap();
    set_in(5'b01111, 36'd0, 48'd1, 48'hFFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp || CARRYOUTF !== exp[48]) begin
        n_err++;
        $display("FAIL wrap cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
    end
    n_cmp++;
    if (P !== 48'd0 || CARRYOUT !== 1'b1 || CARRYOUTF !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_value P=%h CO=%b required 000000000000/1", P, CARRYOUT);
    end
    $display("wrap: P=%h CO=%b", P, CARRYOUT);
  endtask

  task automatic test_subtract();
    set_in(5'b11111, 36'd0, 48'd3, 48'd10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) C = 48'd2;
      if (i == 3) begin CEP = 1'b0; C = 48'd10; end
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp || PCOUT !== exp[47:0]) begin
        n_err++;
        $display("FAIL subtract cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
      if (i == 1) begin
        n_cmp++;
        if (P !== 48'd6 || CARRYOUT !== 1'b0) begin
          n_err++;
          $display("FAIL subtract_pos P=%h CO=%b required 000000000006/0", P, CARRYOUT);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (P !== 48'hFFFF_FFFF_FFFE || CARRYOUT !== 1'b1) begin
          n_err++;
          $display("FAIL subtract_neg P=%h CO=%b required fffffffffffe/1", P, CARRYOUT);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (P !== 48'hFFFF_FFFF_FFFE || CARRYOUT !== 1'b0) begin
          n_err++;
          $display("FAIL carry_without_p P=%h CO=%b required fffffffffffe/0", P, CARRYOUT);
        end
      end
    end
    CEP = 1'b1;
    $display("subtract: P=%h CO=%b", P, CARRYOUT);
  endtask

  task automatic test_mid_reset();
    set_in(5'b01001, 36'd7, 48'd0, 48'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp) begin
        n_err++;
        $display("FAIL mid_reset_pre cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
    end
    #1 RST = 1'b0;
    #1;
    n_cmp++;
    if (P !== 48'd0 || PCOUT !== 48'd0 || CARRYOUT !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_async P=%h CO=%b required 0/0", P, CARRYOUT);
    end
    #1 RST = 1'b1;
    m_p = '0; m_c = 1'b0; m_opm = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp) begin
        n_err++;
        $display("FAIL mid_reset_post cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
    end
    n_cmp++;
    if (P !== 48'd14) begin
      n_err++;
      $display("FAIL mid_reset_resume P=%h required 00000000000e", P);
    end
    $display("mid_reset: resumed P=%h", P);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      OPMODE = 5'($urandom); M = 36'({$urandom, $urandom}); DAB = 48'({$urandom, $urandom});
      C = 48'({$urandom, $urandom}); PCIN = 48'({$urandom, $urandom}); CIN = 1'($urandom);
      CEOPMODE = 1'($urandom); CEP = ($urandom_range(3) != 0); CECARRY = 1'($urandom);
      cycle();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({CARRYOUT, P} !== exp || PCOUT !== exp[47:0] || CARRYOUTF !== exp[48]) begin
        n_err++;
        $display("FAIL back_to_back cyc=%0d got=%h required=%h", i, {CARRYOUT, P}, exp);
      end
    end
    $display("back_to_back: 60 random cycles done");
  endtask

  initial begin
    RST = 1'b0; CEOPMODE = 1'b1; CEP = 1'b1; CECARRY = 1'b1;
    set_in(5'd0, 36'd0, 48'd0, 48'd0, 1'b0);
    PCIN = 48'd0;
    test_reset();
    test_m_select();
    test_accumulate();
    test_wrap();
    test_subtract();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
